// File: rtl/led_disp_pkg.sv
// Shared segment definitions for the multiplexed 7-seg driver.
// Patterns are abcdefg with bit6 = a, active-low.
package led_disp_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t SEG_CODE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic seg_t nibbleToSeg(input logic [3:0] nibble);
        return SEG_CODE[nibble];
    endfunction

endpackage

// File: rtl/led_disp_scan_if.sv
// Bundle between the value source (master) and the scan driver (slave).
// It also carries the board-side segment, dp and anode lines.
interface led_disp_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value_i;
    logic [DIGITS-1:0]   dp_i;
    logic [DIGITS-1:0]   blank_i;
    logic                load_i;
    logic                pending_o;
    logic                frame_o;
    logic [6:0]          seg_o;
    logic                dp_o;
    logic [DIGITS-1:0]   an_o;

    modport master (
        output value_i, dp_i, blank_i, load_i,
        input  pending_o, frame_o, seg_o, dp_o, an_o
    );

    modport slave (
        input  value_i, dp_i, blank_i, load_i,
        output pending_o, frame_o, seg_o, dp_o, an_o
    );
endinterface

// File: rtl/led_disp_scan_seg_decode.sv
// Combinational hex nibble to active-low abcdefg segment pattern.
module seg_decode
    import led_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = nibbleToSeg(nibble_i);
    end

endmodule

// File: rtl/led_disp_scan.sv
// Time-multiplexed common-anode 7-seg driver with a double-buffered display value.
// It provides anti-ghost blanking, per-digit dp and force-blank, and leading-zero suppression.
module led_disp_scan
    import led_disp_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_BLANK     = 1
) (
    input  logic           clk,
    input  logic           rst,
    led_disp_scan_if.slave bus
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] stagedVal_q, stagedVal_d, shadowVal_q, shadowVal_d;
    logic [DIGITS-1:0]   stagedDp_q, stagedDp_d, shadowDp_q, shadowDp_d;
    logic [DIGITS-1:0]   stagedBlank_q, stagedBlank_d, shadowBlank_q, shadowBlank_d;
    logic                pending_q, pending_d;
    logic                frame_q;
    seg_t                seg_q, seg_d;
    logic                dpOut_q, dpOut_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                slotEnd, frameEnd;
    logic [3:0]          curNibble;
    seg_t                decodedSeg;
    logic [DIGITS-1:0]   nibbleZero;
    logic [DIGITS-1:0]   belowIdx;
    logic                leadZero;

    assign slotEnd  = (cnt_q == CNT_LAST);
    assign frameEnd = slotEnd && (idx_q == IDX_LAST);

    // Shadow only changes on a frame boundary so a frame is never torn between two values.
    always_comb begin
        cnt_d         = slotEnd ? '0 : cnt_q + CW'(1);
        idx_d         = idx_q;
        stagedVal_d   = stagedVal_q;
        stagedDp_d    = stagedDp_q;
        stagedBlank_d = stagedBlank_q;
        shadowVal_d   = shadowVal_q;
        shadowDp_d    = shadowDp_q;
        shadowBlank_d = shadowBlank_q;
        pending_d     = pending_q;
        if (slotEnd) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        if (frameEnd && bus.load_i) begin
            shadowVal_d   = bus.value_i;
            shadowDp_d    = bus.dp_i;
            shadowBlank_d = bus.blank_i;
            pending_d     = 1'b0;
        end else if (frameEnd && pending_q) begin
            shadowVal_d   = stagedVal_q;
            shadowDp_d    = stagedDp_q;
            shadowBlank_d = stagedBlank_q;
            pending_d     = 1'b0;
        end else if (bus.load_i) begin
            stagedVal_d   = bus.value_i;
            stagedDp_d    = bus.dp_i;
            stagedBlank_d = bus.blank_i;
            pending_d     = 1'b1;
        end
    end

    assign curNibble = shadowVal_q[4*int'(idx_q) +: 4];

    seg_decode u_seg_decode (
        .nibble_i (curNibble),
        .seg_o    (decodedSeg)
    );

    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            nibbleZero[i] = (shadowVal_q[4*i +: 4] == 4'h0);
        end
        belowIdx = (DIGITS'(1) << idx_q) - DIGITS'(1);
        leadZero = (LZ_BLANK != 0) && (idx_q != '0) && (&(nibbleZero | belowIdx));
    end

    always_comb begin
        seg_d   = SEG_OFF;
        dpOut_d = 1'b1;
        an_d    = '1;
        if (cnt_q >= BLANK_END) begin
            an_d = ~(DIGITS'(1) << idx_q);
            if (!shadowBlank_q[idx_q]) begin
                dpOut_d = ~shadowDp_q[idx_q];
                if (!leadZero) begin
                    seg_d = decodedSeg;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            stagedVal_q   <= '0;
            stagedDp_q    <= '0;
            stagedBlank_q <= '0;
            shadowVal_q   <= '0;
            shadowDp_q    <= '0;
            shadowBlank_q <= '0;
            pending_q     <= 1'b0;
            frame_q       <= 1'b0;
            seg_q         <= SEG_OFF;
            dpOut_q       <= 1'b1;
            an_q          <= '1;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            stagedVal_q   <= stagedVal_d;
            stagedDp_q    <= stagedDp_d;
            stagedBlank_q <= stagedBlank_d;
            shadowVal_q   <= shadowVal_d;
            shadowDp_q    <= shadowDp_d;
            shadowBlank_q <= shadowBlank_d;
            pending_q     <= pending_d;
            frame_q       <= frameEnd;
            seg_q         <= seg_d;
            dpOut_q       <= dpOut_d;
            an_q          <= an_d;
        end
    end

    assign bus.pending_o = pending_q;
    assign bus.frame_o   = frame_q;
    assign bus.seg_o     = seg_q;
    assign bus.dp_o      = dpOut_q;
    assign bus.an_o      = an_q;

endmodule

// File: tb/tb_led_disp_scan.sv
// Self-checking bench for led_disp_scan with 4 digits, 8-cycle slots and 2 blank cycles.
// Expected frames are queued when a load is driven and checked cycle-by-cycle when the frame runs.
module tb_led_disp_scan;

    localparam logic [6:0] OFF = 7'h7F;
    localparam int FRAME = 32;

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic [3:0][6:0] segs;
        logic [3:0]      dpOut;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   phase = 0;
    int   compared = 0;
    int   mismatched = 0;
    vec_t vecs [8];
    vec_t sb [$];

    led_disp_scan_if #(.DIGITS(4)) bus ();

    led_disp_scan #(
        .DIGITS       (4),
        .CLK_DIV      (8),
        .BLANK_CYCLES (2),
        .LZ_BLANK     (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Independent position within the 32-cycle frame, derived only from reset and clock.
    always @(posedge clk or posedge rst) begin
        if (rst) phase <= 0;
        else     phase <= (phase + 1) % FRAME;
    end

    function automatic vec_t mk(input logic [15:0] value, input logic [3:0] dp, input logic [3:0] blank,
                                input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                                input logic [6:0] s3, input logic [3:0] dpOut);
        vec_t v;
        v.value = value;
        v.dp    = dp;
        v.blank = blank;
        v.segs  = {s3, s2, s1, s0};
        v.dpOut = dpOut;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Called at a negedge; drives a one-cycle load and checks the pending flag afterwards.
    task automatic applyStimulus(input vec_t v, input bit push);
        logic expPending;
        expPending = (phase != FRAME - 1);
        bus.value_i = v.value;
        bus.dp_i    = v.dp;
        bus.blank_i = v.blank;
        bus.load_i  = 1'b1;
        if (push) sb.push_back(v);
        @(negedge clk);
        bus.load_i = 1'b0;
        checkOutput("pending_after_load", {15'd0, bus.pending_o}, {15'd0, expPending});
    endtask

    task automatic checkFrame();
        int   guard;
        int   slot;
        int   c;
        vec_t e;
        guard = 0;
        while (phase != 0 && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        if (phase != 0) begin
            checkOutput("frame_wait_timeout", 16'd1, 16'd0);
            return;
        end
        checkOutput("frame_start", {15'd0, bus.frame_o}, 16'd1);
        checkOutput("pending_clear", {15'd0, bus.pending_o}, 16'd0);
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 16'd1, 16'd0);
            return;
        end
        e = sb.pop_front();
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            slot = (k - 1) / 8;
            c    = (k - 1) % 8;
            if (c < 2) begin
                checkOutput("an_dark", {12'd0, bus.an_o}, 16'h000F);
                checkOutput("seg_dark", {9'd0, bus.seg_o}, {9'd0, OFF});
                checkOutput("dp_dark", {15'd0, bus.dp_o}, 16'd1);
            end else begin
                checkOutput("an_lit", {12'd0, bus.an_o}, {12'd0, ~(4'b0001 << slot)});
                checkOutput("seg_lit", {9'd0, bus.seg_o}, {9'd0, e.segs[slot]});
                checkOutput("dp_lit", {15'd0, bus.dp_o}, {15'd0, e.dpOut[slot]});
            end
            checkOutput("frame_pulse", {15'd0, bus.frame_o}, {15'd0, k == FRAME});
        end
    endtask

    task automatic waitPhase(input int target);
        int guard;
        guard = 0;
        while (phase != target && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        if (phase != target) checkOutput("phase_wait_timeout", 16'd1, 16'd0);
    endtask

    initial begin
        bus.value_i = '0;
        bus.dp_i    = '0;
        bus.blank_i = '0;
        bus.load_i  = 1'b0;

        vecs[0] = mk(16'h12AF, 4'b0100, 4'b0000, 7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111, 4'b1011);
        vecs[1] = mk(16'h0005, 4'b0000, 4'b0000, 7'b0100100, OFF, OFF, OFF, 4'b1111);
        vecs[2] = mk(16'h0008, 4'b0001, 4'b0001, OFF, OFF, OFF, OFF, 4'b1111);
        vecs[3] = mk(16'h0000, 4'b0010, 4'b0000, 7'b0000001, OFF, OFF, OFF, 4'b1101);
        vecs[4] = mk(16'hB0C0, 4'b1000, 4'b0010, 7'b0000001, OFF, 7'b0000001, 7'b1100000, 4'b0111);
        vecs[5] = mk(16'h3469, 4'b1111, 4'b0000, 7'b0000100, 7'b0100000, 7'b1001100, 7'b0000110, 4'b0000);
        vecs[6] = mk(16'h0E70, 4'b0000, 4'b1000, 7'b0000001, 7'b0001101, 7'b0110000, OFF, 4'b1111);
        vecs[7] = mk(16'hD000, 4'b0000, 4'b0000, 7'b0000001, 7'b0000001, 7'b0000001, 7'b1000010, 4'b1111);

        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_an", {12'd0, bus.an_o}, 16'h000F);
        checkOutput("reset_seg", {9'd0, bus.seg_o}, {9'd0, OFF});
        checkOutput("reset_dp", {15'd0, bus.dp_o}, 16'd1);
        checkOutput("reset_pending", {15'd0, bus.pending_o}, 16'd0);
        checkOutput("reset_frame", {15'd0, bus.frame_o}, 16'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], 1'b1);
            checkFrame();
        end

        $display("[TB] two loads in one frame, last one wins");
        applyStimulus(mk(16'h1111, 4'b0000, 4'b0000, OFF, OFF, OFF, OFF, 4'b1111), 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(mk(16'h2222, 4'b0000, 4'b0000, 7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010, 4'b1111), 1'b1);
        checkFrame();

        $display("[TB] load on the frame-boundary cycle");
        waitPhase(FRAME - 1);
        applyStimulus(mk(16'h00C7, 4'b0000, 4'b0000, 7'b0001101, 7'b0110001, OFF, OFF, 4'b1111), 1'b1);
        checkFrame();

        $display("[TB] reset in the middle of a scan");
        waitPhase(21);
        checkOutput("prereset_an", {12'd0, bus.an_o}, 16'h000B);
        rst = 1'b1;
        #1;
        checkOutput("midreset_an", {12'd0, bus.an_o}, 16'h000F);
        checkOutput("midreset_seg", {9'd0, bus.seg_o}, {9'd0, OFF});
        checkOutput("midreset_dp", {15'd0, bus.dp_o}, 16'd1);
        checkOutput("midreset_pending", {15'd0, bus.pending_o}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(mk(16'h0000, 4'b0000, 4'b0000, 7'b0000001, OFF, OFF, OFF, 4'b1111));
        @(negedge clk);
        checkOutput("restart_an_1", {12'd0, bus.an_o}, 16'h000F);
        @(negedge clk);
        checkOutput("restart_an_2", {12'd0, bus.an_o}, 16'h000F);
        @(negedge clk);
        checkOutput("restart_an_3", {12'd0, bus.an_o}, 16'h000E);
        checkOutput("restart_seg_3", {9'd0, bus.seg_o}, {9'd0, 7'b0000001});
        checkFrame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
